// File: rtl/amba_lite_master.sv
// AXI4-Lite master for a single-outstanding core load/store port; zero-wait access completes 3 cycles after accept.
// Backpressure: ready is high only in IDLE, VALIDs hold until READY, and slave wait states stretch the transaction.
module amba_lite_master #(
    parameter logic [2:0] PROT = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] AWADDR,
    output logic [2:0]  AWPROT,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic        BVALID,
    input  logic [1:0]  BRESP,
    output logic        BREADY,
    output logic [31:0] ARADDR,
    output logic [2:0]  ARPROT,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic        RVALID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    output logic        RREADY
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        arvalid_q, arvalid_d;
    logic        aw_acc_q, aw_acc_d;
    logic        w_acc_q, w_acc_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        aw_hs, w_hs;
    logic        addr_lo_unused;

    // Accesses are word-aligned, so the byte offset never reaches the bus.
    assign addr_lo_unused = ^addr[1:0];

    assign aw_hs = awvalid_q & AWREADY;
    assign w_hs  = wvalid_q & WREADY;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        aw_acc_d  = aw_acc_q;
        w_acc_d   = w_acc_q;
        err_d     = err_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = {addr[31:2], 2'b00};
                    wdata_d = wdata;
                    wstrb_d = be;
                    if (we) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_acc_d  = 1'b0;
                        w_acc_d   = 1'b0;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently; leave only once both have.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_acc_d  = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_acc_d  = 1'b1;
                end
                if ((aw_acc_q | aw_hs) && (w_acc_q | w_hs)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BVALID) begin
                    err_d   = |BRESP;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            RD_ADDR: begin
                if (arvalid_q && ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (RVALID) begin
                    rdata_d = RDATA;
                    err_d   = |RRESP;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            aw_acc_q  <= 1'b0;
            w_acc_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            aw_acc_q  <= aw_acc_d;
            w_acc_q   <= w_acc_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign BREADY  = (state_q == WR_RESP);
    assign RREADY  = (state_q == RD_DATA);
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign AWADDR  = addr_q;
    assign ARADDR  = addr_q;
    assign AWPROT  = PROT;
    assign ARPROT  = PROT;
    assign AWVALID = awvalid_q;
    assign WVALID  = wvalid_q;
    assign ARVALID = arvalid_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;

endmodule

// File: tb/tb_amba_lite_master.sv
// Bench for amba_lite_master: behavioural AXI4-Lite slave with per-channel delays and a completion scoreboard.
module tb_amba_lite_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        ready, done, err;
    logic [31:0] rdata;
    logic [31:0] AWADDR, WDATA, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, WVALID, ARVALID, BREADY, RREADY;
    logic [3:0]  WSTRB;
    logic        AWREADY = 1'b0, WREADY = 1'b0, ARREADY = 1'b0;
    logic        BVALID = 1'b0, RVALID = 1'b0;
    logic [1:0]  BRESP = 2'b00, RRESP = 2'b00;
    logic [31:0] RDATA = '0;

    amba_lite_master #(.PROT(3'b010)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready), .done(done), .rdata(rdata), .err(err),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY)
    );

    typedef struct {
        logic        rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic rd, input logic [31:0] d, input logic e);
        exp_t r;
        r.rd   = rd;
        r.data = d;
        r.err  = e;
        return r;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: decisions are made on the falling edge, so a READY raised while VALID is
    // high guarantees a handshake on the following rising edge.
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic        aw_got = 0, w_got = 0, ar_got = 0, b_taken = 0, r_taken = 0;
    int          aw_hs = 0, w_hs = 0, ar_hs = 0, bv_cyc = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;

    always @(negedge clk) begin
        if (!reset) begin
            AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_taken = 0; r_taken = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        end else begin
            if (BVALID && b_taken) begin
                BVALID = 0; BRESP = 2'b00; b_taken = 0;
                aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
            end else if (aw_got && w_got && !BVALID) begin
                if (b_wait >= b_dly) begin BVALID = 1; BRESP = bresp_cfg; bv_cyc = cyc; end
                else b_wait++;
            end
            if (BVALID && BREADY) b_taken = 1;

            if (AWVALID && !aw_got) begin
                if (aw_wait >= aw_dly) begin AWREADY = 1; aw_got = 1; aw_hs++; cap_awaddr = AWADDR; end
                else begin AWREADY = 0; aw_wait++; end
            end else AWREADY = 0;

            if (WVALID && !w_got) begin
                if (w_wait >= w_dly) begin
                    WREADY = 1; w_got = 1; w_hs++; cap_wdata = WDATA; cap_wstrb = WSTRB;
                end else begin WREADY = 0; w_wait++; end
            end else WREADY = 0;

            if (RVALID && r_taken) begin
                RVALID = 0; RRESP = 2'b00; r_taken = 0; ar_got = 0; ar_wait = 0; r_wait = 0;
            end else if (ar_got && !RVALID) begin
                if (r_wait >= r_dly) begin RVALID = 1; RDATA = rdata_cfg; RRESP = rresp_cfg; end
                else r_wait++;
            end
            if (RVALID && RREADY) r_taken = 1;

            if (ARVALID && !ar_got) begin
                if (ar_wait >= ar_dly) begin ARREADY = 1; ar_got = 1; ar_hs++; cap_araddr = ARADDR; end
                else begin ARREADY = 0; ar_wait++; end
            end else ARREADY = 0;
        end
    end

    // Monitor: accepts (ready falling), completions and the scoreboard pop.
    int   acc_cyc[64];
    int   done_cyc[64];
    int   acc_cnt = 0, done_cnt = 0, arv_cnt = 0;
    logic ready_prev = 1'b1;
    logic w_low_aw_high = 1'b0;

    always @(negedge clk) begin
        if (ready_prev && !ready && acc_cnt < 64) begin
            acc_cyc[acc_cnt] = cyc - 1;
            acc_cnt++;
        end
        ready_prev = ready;
        if (AWVALID && !WVALID) w_low_aw_high = 1'b1;
        if (ARVALID) arv_cnt++;
        if (done) begin
            if (done_cnt < 64) done_cyc[done_cnt] = cyc;
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_err", 32'(err), 32'(mon_e.err));
                if (mon_e.rd) chk("sb_rdata", rdata, mon_e.data);
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input exp_t e);
        for (int n = 0; n < 200 && !ready; n++) @(negedge clk);
        req = 1; we = w; addr = a; wdata = d; be = b;
        exp_q.push_back(e);
        @(negedge clk);
        req = 0;
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 300 && done_cnt < n; i++) @(negedge clk);
        chk("done_count", done_cnt, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int base, a0, ah, wh, arv0;

    initial begin
        reset = 0; req = 0; we = 0; addr = '0; wdata = '0; be = '0;
        repeat (3) @(negedge clk);
        chk("rst_valids", {29'd0, AWVALID, WVALID, ARVALID}, 32'd0);
        chk("rst_readys", {30'd0, BREADY, RREADY}, 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_awaddr", AWADDR, 32'd0);
        chk("rst_wdata", WDATA, 32'd0);
        chk("rst_wstrb", 32'(WSTRB), 32'd0);
        reset = 1;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("prot", {26'd0, AWPROT, ARPROT}, 32'h12);

        // Zero-wait write, unaligned address
        base = done_cnt; a0 = acc_cnt;
        issue(1, 32'h0000_0013, 32'hDEAD_BEEF, 4'hF, mk(0, 32'd0, 0));
        wait_done(base + 1);
        chk("wr_awaddr", cap_awaddr, 32'h0000_0010);
        chk("wr_wdata", cap_wdata, 32'hDEAD_BEEF);
        chk("wr_wstrb", 32'(cap_wstrb), 32'hF);
        chk("wr_latency", done_cyc[base] - acc_cyc[a0], 3);

        // Skewed write: W accepted 4 cycles before AW, slow B
        aw_dly = 4; w_dly = 0; b_dly = 2; w_low_aw_high = 0; ah = aw_hs; wh = w_hs;
        base = done_cnt;
        issue(1, 32'h0000_0100, 32'hA5A5_0F0F, 4'h3, mk(0, 32'd0, 0));
        wait_done(base + 1);
        chk("skew_w_drops", 32'(w_low_aw_high), 32'd1);
        chk("skew_aw_hs", aw_hs - ah, 1);
        chk("skew_w_hs", w_hs - wh, 1);
        chk("skew_done_after_b", done_cyc[base] - bv_cyc, 1);
        chk("skew_wstrb", 32'(cap_wstrb), 32'h3);
        aw_dly = 0; b_dly = 0;

        // Read with 2-cycle ARREADY delay
        ar_dly = 2; r_dly = 1; rdata_cfg = 32'h1234_5678; rresp_cfg = 2'b00;
        base = done_cnt; arv0 = arv_cnt;
        issue(0, 32'h0000_2002, 32'd0, 4'h0, mk(1, 32'h1234_5678, 0));
        wait_done(base + 1);
        chk("rd_arvalid_cycles", arv_cnt - arv0, 3);
        chk("rd_araddr", cap_araddr, 32'h0000_2000);
        repeat (3) @(negedge clk);
        chk("rd_rdata_held", rdata, 32'h1234_5678);
        ar_dly = 0; r_dly = 0;

        // Error write with empty strobe, then a clean read
        bresp_cfg = 2'b10;
        base = done_cnt;
        issue(1, 32'h0000_0044, 32'h5555_AAAA, 4'h0, mk(0, 32'd0, 1));
        wait_done(base + 1);
        chk("err_wstrb_zero", 32'(cap_wstrb), 32'd0);
        bresp_cfg = 2'b00; rdata_cfg = 32'hCAFE_F00D;
        base = done_cnt; a0 = acc_cnt;
        issue(0, 32'h0000_0048, 32'd0, 4'h0, mk(1, 32'hCAFE_F00D, 0));
        wait_done(base + 1);
        chk("rd_latency", done_cyc[base] - acc_cyc[a0], 3);

        // Back-to-back: write then read with req held high; read returns an error
        rdata_cfg = 32'h0F0F_0F0F; rresp_cfg = 2'b01;
        base = done_cnt; a0 = acc_cnt;
        req = 1; we = 1; addr = 32'h0000_0200; wdata = 32'h1111_2222; be = 4'hC;
        exp_q.push_back(mk(0, 32'd0, 0));
        @(negedge clk);
        we = 0; addr = 32'h0000_0300;
        exp_q.push_back(mk(1, 32'h0F0F_0F0F, 1));
        for (int i = 0; i < 100 && acc_cnt < a0 + 2; i++) @(negedge clk);
        req = 0;
        wait_done(base + 2);
        chk("b2b_no_idle", acc_cyc[a0 + 1], done_cyc[base]);
        chk("b2b_araddr", cap_araddr, 32'h0000_0300);
        rresp_cfg = 2'b00;

        // Reset while ARVALID is high
        ar_dly = 50;
        issue(0, 32'h0000_3000, 32'd0, 4'h0, mk(1, 32'd0, 0));
        @(negedge clk);
        chk("rst_pre_arvalid", 32'(ARVALID), 32'd1);
        #2 reset = 0;
        #1;
        chk("rst_async_valids", {29'd0, AWVALID, WVALID, ARVALID}, 32'd0);
        chk("rst_async_rready", 32'(RREADY), 32'd0);
        exp_q.delete();
        base = done_cnt;
        repeat (2) @(negedge clk);
        reset = 1;
        ar_dly = 0;
        @(negedge clk);
        chk("rst_no_done", done_cnt, base);
        chk("rst_ready_release", 32'(ready), 32'd1);
        rdata_cfg = 32'h0BAD_F00D;
        issue(0, 32'h0000_4444, 32'd0, 4'h0, mk(1, 32'h0BAD_F00D, 0));
        wait_done(base + 1);
        chk("post_rst_araddr", cap_araddr, 32'h0000_4444);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
